// File: rtl/counter_pkg.sv
// Shared types and step clamping for the up/down modulus counter.
// Used by both the RTL and the bench reference model.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  localparam int CNT_MAX_W = 32;

  function automatic logic [CNT_MAX_W-1:0] clamp_step(
    input logic [CNT_MAX_W-1:0] step,
    input logic [CNT_MAX_W-1:0] limit
  );
    return (step > limit) ? limit : step;
  endfunction

endpackage

// File: rtl/counter_ud_mod_if.sv
// Control/status bundle for counter_ud_mod.
// COUNTER_MATCH_EN adds match_val/match.
interface counter_ud_mod_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic [WIDTH-1:0] count;
  logic             rollover;
  logic             underflow;
  logic             at_limit;
  logic             at_zero;
`ifdef COUNTER_MATCH_EN
  logic [WIDTH-1:0] match_val;
  logic             match;

  modport master (
    output en, load_en, load, down,
    output step, limit, sat_mode, match_val,
    input  count, rollover, underflow,
    input  at_limit, at_zero, match
  );

  modport slave (
    input  en, load_en, load, down,
    input  step, limit, sat_mode, match_val,
    output count, rollover, underflow,
    output at_limit, at_zero, match
  );
`else
  modport master (
    output en, load_en, load, down,
    output step, limit, sat_mode,
    input  count, rollover, underflow,
    input  at_limit, at_zero
  );

  modport slave (
    input  en, load_en, load, down,
    input  step, limit, sat_mode,
    output count, rollover, underflow,
    output at_limit, at_zero
  );
`endif
endinterface

// File: rtl/counter_ud_next.sv
// Combinational next-count and bound-event calculator.
// Range fix-up priority is left to the owner of the register.
module counter_ud_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf,
  output logic             unf,
  output logic             out_of_range
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  cnt_mode_e        mode;
  cnt_dir_e         dir;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   c_x;
  logic [WIDTH:0]   s_x;
  logic [WIDTH:0]   l_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   span;

  assign mode     = cnt_mode_e'(sat_mode);
  assign dir      = cnt_dir_e'(down);
  assign step_eff = WIDTH'(clamp_step(
                      CNT_MAX_W'(step), CNT_MAX_W'(limit)));
  assign c_x      = {1'b0, count};
  assign s_x      = {1'b0, step_eff};
  assign l_x      = {1'b0, limit};
  assign sum      = c_x + s_x;
  assign span     = l_x + ONE;

  assign out_of_range = count > limit;

  always_comb begin
    next_count = count;
    ovf        = 1'b0;
    unf        = 1'b0;
    // limit 0 clamps step_eff to 0, yet a raw step still crosses a bound
    if (limit == '0) begin
      next_count = '0;
      if (step != '0) begin
        ovf = (dir == CNT_UP);
        unf = (dir == CNT_DOWN);
      end
    end else if (step_eff == '0) begin
      next_count = count;
    end else if (dir == CNT_UP) begin
      if (sum > l_x) begin
        ovf        = 1'b1;
        next_count = (mode == CNT_SAT) ? limit
                                       : WIDTH'(sum - span);
      end else begin
        next_count = WIDTH'(sum);
      end
    end else begin
      if (count >= step_eff) begin
        next_count = count - step_eff;
      end else begin
        unf        = 1'b1;
        next_count = (mode == CNT_SAT) ? '0
                                       : WIDTH'(c_x + span - s_x);
      end
    end
  end

endmodule

// File: rtl/counter_ud_mod.sv
// Up/down modulus counter: load, step, wrap/saturate, bound pulses.
// Optional COUNTER_MATCH_EN adds a registered match pulse.
module counter_ud_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  counter_ud_mod_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamp;
  logic             roll_q;
  logic             roll_d;
  logic             unf_q;
  logic             unf_d;
  logic             ovf;
  logic             unf;
  logic             oor;

  counter_ud_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count        (count_q),
    .step         (bus.step),
    .limit        (bus.limit),
    .down         (bus.down),
    .sat_mode     (bus.sat_mode),
    .next_count   (next_count),
    .ovf          (ovf),
    .unf          (unf),
    .out_of_range (oor)
  );

  assign load_clamp = (bus.load > bus.limit) ? bus.limit
                                             : bus.load;

  always_comb begin
    count_d = count_q;
    roll_d  = 1'b0;
    unf_d   = 1'b0;
    if (bus.load_en) begin
      count_d = load_clamp;
    end else if (bus.en && oor) begin
      // limit shrank under the count: snap back, no step, no pulse
      count_d = (cnt_mode_e'(bus.sat_mode) == CNT_SAT)
                ? bus.limit : '0;
    end else if (bus.en) begin
      count_d = next_count;
      roll_d  = ovf;
      unf_d   = unf;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.rollover  = roll_q;
  assign bus.underflow = unf_q;
  assign bus.at_limit  = (count_q == bus.limit);
  assign bus.at_zero   = (count_q == '0);

`ifdef COUNTER_MATCH_EN
  logic match_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_q <= 1'b0;
    end else begin
      match_q <= (count_d == bus.match_val) &&
                 (count_q != bus.match_val);
    end
  end

  assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_counter_ud_mod.sv
// Table-driven, scoreboarded bench for counter_ud_mod (WIDTH=8),
// followed by a model-checked random run.
module tb_counter_ud_mod;
  import counter_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic         ld;
    logic [W-1:0] ldv;
    logic         en;
    logic         dn;
    logic [W-1:0] st;
    logic [W-1:0] lim;
    logic         sat;
    logic [W-1:0] c;
    logic         ro;
    logic         uf;
  } vec_t;

  typedef struct {
    logic [W+3:0] v;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  counter_ud_mod_if #(.WIDTH(W)) bus ();

  counter_ud_mod #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(
    input logic ld, input int ldv, input logic en,
    input logic dn, input int st, input int lim,
    input logic sat, input int c, input logic ro,
    input logic uf
  );
    vec_t x;
    x.ld  = ld;
    x.ldv = W'(ldv);
    x.en  = en;
    x.dn  = dn;
    x.st  = W'(st);
    x.lim = W'(lim);
    x.sat = sat;
    x.c   = W'(c);
    x.ro  = ro;
    x.uf  = uf;
    return x;
  endfunction

  function automatic logic [W+3:0] outs();
    return {bus.count, bus.rollover, bus.underflow,
            bus.at_limit, bus.at_zero};
  endfunction

  task automatic chk(input string tag,
                     input logic [W+3:0] got,
                     input logic [W+3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d ro=%b uf=%b al=%b az=%b, want cnt=%0d ro=%b uf=%b al=%b az=%b",
               tag, got[W+3:4], got[3], got[2], got[1], got[0],
               exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.load_en  = x.ld;
    bus.load     = x.ldv;
    bus.en       = x.en;
    bus.down     = x.dn;
    bus.step     = x.st;
    bus.limit    = x.lim;
    bus.sat_mode = x.sat;
  endtask

  task automatic run(input vec_t x, input string tag);
    exp_t e;
    drive(x);
    e.v   = {x.c, x.ro, x.uf, x.c == x.lim, x.c == '0};
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got none want one", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, outs(), e.v);
    end
  endtask

`ifdef COUNTER_MATCH_EN
  task automatic mchk(input string tag, input logic exp);
    checks++;
    if (bus.match !== exp) begin
      errors++;
      $display("FAIL %s: got match=%b want %b",
               tag, bus.match, exp);
    end
  endtask
`endif

  initial begin
    int   c;
    int   lim;
    int   se;
    vec_t x;
    logic ro;
    logic uf;

    rstn         = 1'b0;
    bus.en       = 1'b0;
    bus.load_en  = 1'b0;
    bus.load     = '0;
    bus.down     = 1'b0;
    bus.step     = W'(1);
    bus.limit    = W'(9);
    bus.sat_mode = 1'b0;
`ifdef COUNTER_MATCH_EN
    bus.match_val = W'(255);
`endif

    #3;
    chk("reset_state", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    bus.limit = '0;
    #1;
    chk("reset_lim0", outs(), {8'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    bus.limit = W'(9);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // up wrap 0..9,0 with rollover on the wrap
    for (int k = 1; k <= 10; k++)
      tbl.push_back(v(0, 0, 1, 0, 1, 9, 0, k % 10, k == 10, 0));
    // down wrap / sat below zero
    tbl.push_back(v(1, 2, 0, 0, 4, 9, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 4, 9, 0, 8, 0, 1));
    tbl.push_back(v(1, 2, 0, 1, 4, 9, 1, 2, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 4, 9, 1, 0, 0, 1));
    tbl.push_back(v(1, 9, 0, 1, 4, 9, 0, 9, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 4, 9, 0, 5, 0, 0));
    // up saturate, repeated rollover at the limit
    tbl.push_back(v(1, 198, 0, 0, 5, 200, 1, 198, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 5, 200, 1, 200, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 5, 200, 1, 200, 1, 0));
    tbl.push_back(v(1, 198, 0, 0, 5, 200, 0, 198, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 5, 200, 0, 2, 1, 0));
    // limit dropped under the count
    tbl.push_back(v(1, 150, 0, 0, 1, 200, 0, 150, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 100, 0, 150, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 100, 0, 0, 0, 0));
    tbl.push_back(v(1, 150, 0, 0, 1, 200, 1, 150, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 100, 1, 100, 0, 0));
    // load beats en, load clamped, step 0 holds
    tbl.push_back(v(1, 250, 1, 0, 3, 100, 0, 100, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 100, 0, 100, 0, 0));
    // limit 0: fix-up first, then pulses every enabled cycle
    tbl.push_back(v(0, 0, 1, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 3, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 3, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // step larger than limit is clamped to limit
    tbl.push_back(v(1, 5, 0, 0, 200, 9, 0, 5, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 200, 9, 0, 4, 1, 0));

    foreach (tbl[i])
      run(tbl[i], $sformatf("vec%0d", i));

    // reset with a rollover about to be registered
    run(v(1, 7, 0, 0, 3, 9, 0, 7, 0, 0), "pre_rst");
    drive(v(0, 0, 1, 0, 3, 9, 0, 0, 0, 0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_async", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    chk("rst_hold", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rstn = 1'b1;

    // reset while a registered rollover pulse is high
    run(v(1, 9, 0, 0, 1, 9, 0, 9, 0, 0), "pre_rst2");
    run(v(0, 0, 1, 0, 1, 9, 0, 0, 1, 0), "roll_live");
    bus.en = 1'b0;
    rstn   = 1'b0;
    #1;
    chk("rst_pulse", outs(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // random run against a reference model
    c   = 0;
    lim = 9;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0)
        case ($urandom_range(0, 4))
          0:       lim = 0;
          1:       lim = 1;
          2:       lim = 255;
          3:       lim = 9;
          default: lim = $urandom_range(2, 254);
        endcase
      else if ($urandom_range(0, 29) == 0)
        lim = $urandom_range(0, lim);
      x.ld  = (i == 0) || ($urandom_range(0, 9) == 0);
      x.ldv = W'($urandom);
      x.en  = ($urandom_range(0, 3) != 0);
      x.dn  = 1'($urandom_range(0, 1));
      x.st  = ($urandom_range(0, 1) != 0)
              ? W'($urandom_range(0, 4)) : W'($urandom);
      x.lim = W'(lim);
      x.sat = 1'($urandom_range(0, 1));
      ro = 1'b0;
      uf = 1'b0;
      se = int'(clamp_step(32'(x.st), 32'(lim)));
      if (x.ld) begin
        c = (int'(x.ldv) > lim) ? lim : int'(x.ldv);
      end else if (x.en) begin
        if (c > lim) begin
          c = x.sat ? lim : 0;
        end else if (lim == 0) begin
          if (x.st != 0) begin
            ro = !x.dn;
            uf = x.dn;
          end
        end else if (x.dn) begin
          if (c >= se) c = c - se;
          else begin
            uf = 1'b1;
            c  = x.sat ? 0 : c + lim + 1 - se;
          end
        end else begin
          if (c + se > lim) begin
            ro = 1'b1;
            c  = x.sat ? lim : c + se - lim - 1;
          end else c = c + se;
        end
      end
      x.c  = W'(c);
      x.ro = ro;
      x.uf = uf;
      run(x, $sformatf("rand%0d", i));
    end

`ifdef COUNTER_MATCH_EN
    @(negedge clk);
    rstn = 1'b0;
    #1;
    mchk("match_rst", 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    bus.match_val = W'(3);
    for (int k = 1; k <= 5; k++) begin
      run(v(0, 0, 1, 0, 1, 9, 0, k, 0, 0), $sformatf("mcnt%0d", k));
      mchk($sformatf("match_cnt%0d", k), k == 3);
    end
    run(v(1, 3, 0, 0, 1, 9, 0, 3, 0, 0), "mload");
    mchk("match_load", 1'b1);
    run(v(0, 0, 0, 0, 1, 9, 0, 3, 0, 0), "mhold");
    mchk("match_hold", 1'b0);
    run(v(0, 0, 1, 0, 0, 9, 0, 3, 0, 0), "mstep0");
    mchk("match_step0", 1'b0);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
